mem_stage_lsu: RTL

Memory-stage load/store unit for the pipelined RISC-V core. It sits between the execute-to-memory pipeline register and the memory-to-writeback boundary. It consumes the M-stage datapath and control signals, runs a req/ack handshake against a variable-latency data memory, and stalls the upstream pipeline while an access is outstanding. It also contains the M/W pipeline register, so loads reach writeback with their read data attached.

---
 rtl/mem_stage_lsu_if.sv | 21 ++
 rtl/mem_stage_lsu.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the M-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack access to a variable-latency data memory,
// upstream stall while an access is outstanding, and the M/W pipeline register.
module mem_stage_lsu #(
    parameter int TIMEOUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] wr_data_m,
    input  logic [DATA_W-1:0] pc_plus4_m,
    input  logic [4:0]        write_addr_m,
    input  logic              reg_write_m,
    input  logic              mem_write_m,
    input  logic [1:0]        result_src_m,
    mem_stage_lsu_if.master   mem,
    output logic              stall_m,
    output logic              mem_fault,
    output logic [DATA_W-1:0] read_data_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [DATA_W-1:0] pc_plus4_w,
    output logic [4:0]        write_addr_w,
    output logic [1:0]        result_src_w,
    output logic              reg_write_w
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state, state_next;
    logic [7:0]        cnt, cnt_next;
    logic [DATA_W-1:0] rdata_cap, rdata_cap_next;
    logic              req_next, we_next, fault_next;
    logic [DATA_W-1:0] addr_next, wdata_next;
    logic              w_load;
    logic [DATA_W-1:0] w_rdata;
    logic              access_m;

    assign access_m = mem_write_m | (result_src_m == 2'b01);

    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        rdata_cap_next = rdata_cap;
        req_next       = mem.mem_req;
        we_next        = mem.mem_we;
        addr_next      = mem.mem_addr;
        wdata_next     = mem.mem_wdata;
        fault_next     = mem_fault;
        stall_m        = 1'b0;
        w_load         = 1'b0;
        w_rdata        = '0;
        case (state)
            IDLE: begin
                if (access_m) begin
                    stall_m    = 1'b1;
                    addr_next  = alu_result_m;
                    wdata_next = wr_data_m;
                    we_next    = mem_write_m;
                    req_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = BUSY;
                end else begin
                    w_load = 1'b1;
                end
            end
            BUSY: begin
                stall_m = 1'b1;
                // An ack on the final counted cycle still wins over the timeout.
                if (mem.mem_ack) begin
                    rdata_cap_next = mem.mem_we ? '0 : mem.mem_rdata;
                    req_next       = 1'b0;
                    state_next     = DONE;
                end else if (cnt == CNT_LAST) begin
                    rdata_cap_next = '0;
                    req_next       = 1'b0;
                    fault_next     = 1'b1;
                    state_next     = DONE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DONE: begin
                w_load     = 1'b1;
                w_rdata    = rdata_cap;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rdata_cap     <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem_fault     <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            rdata_cap     <= rdata_cap_next;
            mem.mem_req   <= req_next;
            mem.mem_we    <= we_next;
            mem.mem_addr  <= addr_next;
            mem.mem_wdata <= wdata_next;
            mem_fault     <= fault_next;
        end
    end

    // M/W register: real fields when the instruction advances, an all-zero bubble otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data_w  <= '0;
            alu_result_w <= '0;
            pc_plus4_w   <= '0;
            write_addr_w <= '0;
            result_src_w <= '0;
            reg_write_w  <= 1'b0;
        end else if (w_load) begin
            read_data_w  <= w_rdata;
            alu_result_w <= alu_result_m;
            pc_plus4_w   <= pc_plus4_m;
            write_addr_w <= write_addr_m;
            result_src_w <= result_src_m;
            reg_write_w  <= reg_write_m;
        end else begin
            read_data_w  <= '0;
            alu_result_w <= '0;
            pc_plus4_w   <= '0;
            write_addr_w <= '0;
            result_src_w <= '0;
            reg_write_w  <= 1'b0;
        end
    end
endmodule
